shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one 8-bit barrel_shifter (combinational rotate-right by s[2:0]) among NUM_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake on each request port and on the single result port.
//  - One registered result stage between the shared shifter and the consumer.
//  - Sits between the ALU operand/issue logic and the result writeback path.
// PARAMETERS
//  NUM_REQ  4                  number of requesters; power of 2, >= 2
//  ID_W     $clog2(NUM_REQ)    width of the requester tag on the result
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          synchronous reset, active low
//  req_valid  in   NUM_REQ    request k valid
//  req_ready  out  NUM_REQ    request k accepted this cycle; one-hot or zero
//  req_data   in   8*NUM_REQ  operand of request k at bits [8k+7:8k]
//  req_amt    in   3*NUM_REQ  rotate amount of request k at bits [3k+2:3k]
//  req_dir    in   NUM_REQ    0 = rotate right, 1 = rotate left
//  rsp_valid  out  1          result register holds a valid result
//  rsp_ready  in   1          consumer accepts the result
//  rsp_data   out  8          rotated operand
//  rsp_id     out  ID_W       index of the requester that produced rsp_data
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=IDLE.
//    - req_ready is 0 while rst_n=0.
//    - A result in flight when reset is asserted is discarded.
//  - FSM states:
//    - IDLE: result register empty.
//    - FULL: result held until taken.
//    - IDLE->FULL on a grant.
//    - FULL->IDLE when rsp_ready=1 and no grant.
//    - FULL->FULL when rsp_ready=1 and a grant (back-to-back) occur together, or when rsp_ready=0.
//  - Slot free: free = (state==IDLE) | rsp_ready. This is a combinational path from rsp_ready to req_ready.
//  - Grant rule:
//    - When free=1, grant the first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//    - req_ready[k]=1 only for the granted k. No valid requests means no grant.
//    - Handshake on port k completes when req_valid[k] & req_ready[k].
//    - A requester must hold its valid, data, amt and dir stable until accepted.
//  - Pointer: after a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
//  - Shift: the muxed operand of the granted port drives the shared shifter in the same cycle.
//    - s = amt when dir=0.
//    - s = (8-amt) mod 8 when dir=1, computed with 3-bit wraparound, so amt=0 gives s=0.
//    - Right rotate: out[j] = in[(j+s) mod 8].
//  - Latency: a grant in cycle n gives rsp_valid=1 with rsp_data and rsp_id in cycle n+1.
//    - Throughput is 1 result per cycle while rsp_ready=1.
//  - Backpressure: while rsp_valid=1 and rsp_ready=0:
//    - rsp_data and rsp_id stay stable.
//    - No grant is issued.
//    - rr_ptr holds.
//  - Fairness: each of N continuously valid requesters is granted once every N grants.
// CONFIGURATION
//  SHIFT_ARB_STALL_CNT_EN
//    - Defined: adds output port stall_cnt (16 bits).
//      - Increments each cycle with rsp_valid & ~rsp_ready.
//      - Saturates at 16'hFFFF.
//      - Reset to 0.
//    - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - shift_arb_pkg holds:
//    - state enum {IDLE, FULL}
//    - DATA_W=8 and AMT_W=3 constants
//    - function rot_amt(amt, dir) giving the effective right-rotate amount
//  - Sub-module rr_arbiter: request vector, ptr and enable in; one-hot grant and encoded index out.
//  - Top level instantiates rr_arbiter and the existing barrel_shifter, plus the operand mux, FSM and result register.
// TESTING
//  1. Reset with all req_valid=1 -> rsp_valid=0, req_ready=0. First cycle after reset grants req 0.
//  2. Right rotate: req0 data=0x81, amt=1, dir=0, rsp_ready=1 -> next cycle rsp_data=0xC0, rsp_id=0.
//  3. Left rotate: req2 data=0x81, amt=3, dir=1 -> rsp_data=0x0C, rsp_id=2. Also amt=0, dir=1 -> data unchanged.
//  4. Round robin: all 4 requesters valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles,
//     rsp_id following one cycle later.
//  5. Backpressure: rsp_ready=0 for 3 cycles with req1 valid ->
//     - req_ready=0 and rsp_data held.
//     - stall_cnt=3 when SHIFT_ARB_STALL_CNT_EN is defined.
//     - When rsp_ready rises, req1 is granted in the same cycle.
//  6. Reset mid-operation: rst_n=0 while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0 and rr_ptr=0;
//     the held result is never delivered.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared types, widths and rotate-amount helper for the shift_arbiter block.
package shift_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Effective right-rotate amount; a left rotate by amt is a right rotate by (8-amt) mod 8.
  function automatic logic [AMT_W-1:0] rot_amt(input logic [AMT_W-1:0] amt, input logic dir);
    return dir ? (AMT_W'(0) - amt) : amt;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit rotate-right by s.
module barrel_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  s,
  output logic [DATA_W-1:0] out_data
);

  // Bit j takes input bit (j+s) mod 8; the 3-bit index add wraps naturally.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < int'(DATA_W); j++) begin
      out_data[j] = in_data[AMT_W'(j) + s];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr wins, modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx
);

  // Search ptr, ptr+1, ... with ID_W-bit wraparound (N is a power of two).
  always_comb begin
    logic             found;
    logic [ID_W-1:0]  k;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < int'(N); i++) begin
      k = ptr + ID_W'(i);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin shared rotate unit with one registered result stage.
// Optional: define SHIFT_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  input  logic [AMT_W*NUM_REQ-1:0]    req_amt,
  input  logic [NUM_REQ-1:0]          req_dir,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ID_W-1:0]             rsp_id
`ifdef SHIFT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  state_t              state_q, state_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                free;
  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [DATA_W-1:0]   sel_data;
  logic [AMT_W-1:0]    sel_amt;
  logic                sel_dir;
  logic [AMT_W-1:0]    shift_s;
  logic [DATA_W-1:0]   shift_out;

  // Slot is free when empty or being drained this cycle; never grant in reset.
  always_comb begin
    free   = (state_q == IDLE) | rsp_ready;
    arb_en = free & rst_n;
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign req_ready = gnt;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (gnt[k]) begin
        sel_data = req_data[k*DATA_W +: DATA_W];
        sel_amt  = req_amt[k*AMT_W +: AMT_W];
        sel_dir  = req_dir[k];
      end
    end
    shift_s = rot_amt(sel_amt, sel_dir);
  end

  barrel_shifter u_barrel_shifter (
    .in_data  (sel_data),
    .s        (shift_s),
    .out_data (shift_out)
  );

  // Next state of the result register, pointer and FSM.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_any) begin
      rsp_data_d = shift_out;
      rsp_id_d   = gnt_idx;
      rr_ptr_d   = gnt_idx + ID_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d     = FULL;
          rsp_valid_d = 1'b1;
        end
      end
      FULL: begin
        if (rsp_ready && !gnt_any) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles a valid result is refused, saturating at all ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rsp_valid_q && !rsp_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter against a behavioural queue-free model.
module tb_shift_arbiter;

  localparam int N = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [8*N-1:0]    req_data;
  logic [3*N-1:0]    req_amt;
  logic [N-1:0]      req_dir;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [1:0]        rsp_id;
`ifdef SHIFT_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  // Per-requester stimulus.
  logic       pv[N];
  logic [7:0] pd[N];
  logic [2:0] pa[N];
  logic       pdir[N];

  // Reference model state.
  bit m_valid = 0;
  int m_data  = 0;
  int m_id    = 0;
  int m_ptr   = 0;
  int m_stall = 0;

  int n_checks = 0;
  int n_fail   = 0;

  shift_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_valid[k]         = pv[k];
      req_data[8*k +: 8]   = pd[k];
      req_amt[3*k +: 3]    = pa[k];
      req_dir[k]           = pdir[k];
    end
  end

  // Rotate computed arithmetically: dir=0 right by a, dir=1 left by a.
  function automatic int exp_rot(int d, int a, bit dir);
    if (!dir) return ((d >> a) | (d << (8 - a))) & 255;
    return ((d << a) | (d >> (8 - a))) & 255;
  endfunction

  // Index the model grants this cycle, or -1.
  function automatic int exp_gnt();
    int k;
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (pv[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] v;
    g = exp_gnt();
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance one clock and the model alongside it.
  task automatic tick();
    int g;
    g = exp_gnt();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_stall = 0;
    end else begin
      if (m_valid && !rsp_ready && m_stall < 65535) m_stall++;
      if (g >= 0) begin
        m_valid = 1;
        m_data  = exp_rot(pd[g], pa[g], pdir[g]);
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b0; pd[k] = 8'h00; pa[k] = 3'd0; pdir[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b1; pd[k] = 8'(k + 1); pa[k] = 3'(k); pdir[k] = 1'b0;
    end
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tick(); tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++;
    if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp_regs data=%h id=%0d exp 00/0", rsp_data, rsp_id);
    end
`ifdef SHIFT_ARB_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_first_rsp valid=%b id=%0d exp 1/0", rsp_valid, rsp_id);
    end
  endtask

  task automatic test_right_rotate();
    do_reset();
    clear_reqs();
    rsp_ready = 1'b1;
    pv[0] = 1'b1; pd[0] = 8'h81; pa[0] = 3'd1; pdir[0] = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_ready got=%b exp=0001", req_ready); end
    tick();
    pv[0] = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hC0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL right_rotate valid=%b data=%h id=%0d exp 1/c0/0", rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_left_rotate();
    clear_reqs();
    rsp_ready = 1'b1;
    pv[2] = 1'b1; pd[2] = 8'h81; pa[2] = 3'd3; pdir[2] = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL left_ready got=%b exp=0100", req_ready); end
    tick();
    n_checks++;
    if (rsp_data !== 8'h0C || rsp_id !== 2'd2 || rsp_data !== 8'(m_data)) begin
      n_fail++; $display("FAIL left_rotate data=%h id=%0d exp 0c/2", rsp_data, rsp_id);
    end
    pd[2] = 8'h5A; pa[2] = 3'd0; pdir[2] = 1'b1;
    tick();
    pv[2] = 1'b0;
    n_checks++;
    if (rsp_data !== 8'h5A || rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL left_rotate_amt0 data=%h id=%0d exp 5a/2", rsp_data, rsp_id);
    end
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] ev;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b1; pd[k] = 8'($urandom); pa[k] = 3'($urandom); pdir[k] = 1'($urandom);
    end
    for (int i = 0; i < 5; i++) begin
      ev = '0;
      ev[seq[i]] = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== ev) begin n_fail++; $display("FAIL rr_grant_%0d got=%b exp=%b", i, req_ready, ev); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(seq[i]) || rsp_data !== 8'(m_data)) begin
        n_fail++; $display("FAIL rr_rsp_%0d valid=%b id=%0d data=%h exp id=%0d data=%h",
                           i, rsp_valid, rsp_id, rsp_data, seq[i], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_reqs();
    rsp_ready = 1'b1;
    pv[1] = 1'b1; pd[1] = 8'h3C; pa[1] = 3'd2; pdir[1] = 1'b0;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_%0d got=%b exp=0000", i, req_ready); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h0F || rsp_id !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold_%0d valid=%b data=%h id=%0d exp 1/0f/1", i, rsp_valid, rsp_data, rsp_id);
      end
    end
`ifdef SHIFT_ARB_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); end
`endif
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
    tick();
    pv[1] = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_after valid=%b id=%0d exp 1/1", rsp_valid, rsp_id);
    end
  endtask

  task automatic test_reset_mid();
    clear_reqs();
    rsp_ready = 1'b1;
    pv[3] = 1'b1; pd[3] = 8'hA5; pa[3] = 3'd4;
    tick();
    pv[3] = 1'b0;
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", rsp_valid); end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) pv[k] = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_ptr got=%b exp=0001", req_ready); end
    tick();
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_data !== 8'(m_data)) begin
      n_fail++; $display("FAIL mid_reset_rsp id=%0d data=%h exp 0/%h", rsp_id, rsp_data, m_data);
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    clear_reqs();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k] && ($urandom_range(0, 2) != 0)) begin
          pv[k] = 1'b1; pd[k] = 8'($urandom); pa[k] = 3'($urandom); pdir[k] = 1'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      g = exp_gnt();
      n_checks++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      tick();
      if (g >= 0) pv[g] = 1'b0;
      n_checks++;
      if (rsp_valid !== m_valid ||
          (m_valid && (rsp_data !== 8'(m_data) || rsp_id !== 2'(m_id)))) begin
        n_fail++; $display("FAIL rand_rsp c=%0d valid=%b data=%h id=%0d exp %b/%h/%0d",
                           c, rsp_valid, rsp_data, rsp_id, m_valid, m_data, m_id);
      end
`ifdef SHIFT_ARB_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 16'(m_stall)) begin
        n_fail++; $display("FAIL rand_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    clear_reqs();
    #1;
    test_reset();
    test_right_rotate();
    test_left_rotate();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
